multiplicador_sd_param: RTL and testbench

MULTIPLICADOR_SD_PARAM -- requirements
Module: multiplicador_sd_param

---
 rtl/multiplicador_pkg.sv | 14 +
 rtl/contador_param.sv | 30 +++
 rtl/multiplicador_sd_param.sv | 110 +++++++++++
 tb/tb_multiplicador_sd_param.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multiplicador_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding
// and the default operand width.
package multiplicador_pkg;

    localparam int W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/contador_param.sv
// Iteration down-counter: loads a start value, decrements to zero and
// holds there, exposing a zero flag for terminal-count detection.
module contador_param #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          dec,
    input  logic [CW-1:0] init,
    output logic          zero
);

    logic [CW-1:0] count;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= init;
        end else if (dec && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    // Terminal-count flag.
    always_comb zero = (count == '0);

endmodule

// File: rtl/multiplicador_sd_param.sv
// Sequential shift-and-add multiplier, unsigned or two's-complement signed.
// Signed operands are reduced to magnitudes on capture; the sign is
// reapplied when the result is written.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for st; captures operands, mode and sign
// CALC  | one add/shift iteration per cycle, W iterations in total
// FIX   | writes produto, negating it for a negative signed result
// DONE  | one-cycle done pulse, then back to IDLE
module multiplicador_sd_param
    import multiplicador_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           st,
    input  logic           sinal,
    input  logic [W-1:0]   multiplicando,
    input  logic [W-1:0]   multiplicador,
    output logic [2*W-1:0] produto,
    output logic           done,
    output logic           idle
);

    localparam int            CW       = $clog2(W);
    localparam logic [CW-1:0] CNT_INIT = CW'(W - 1);

    state_t       state;
    state_t       state_next;
    logic [W-1:0] mcand;
    logic [2*W:0] acc;
    logic         neg;
    logic         cnt_zero;
    logic         start;
    logic [W-1:0] mag_a;
    logic [W-1:0] mag_b;
    logic [W:0]   sum;
    logic [2*W:0] acc_step;

    contador_param #(.CW(CW)) u_contador (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start),
        .dec   (state == CALC),
        .init  (CNT_INIT),
        .zero  (cnt_zero)
    );

    // Operand magnitudes and one add/shift step of the accumulator.
    always_comb begin
        start    = (state == IDLE) && st;
        mag_a    = (sinal && multiplicando[W-1]) ? -multiplicando : multiplicando;
        mag_b    = (sinal && multiplicador[W-1]) ? -multiplicador : multiplicador;
        sum      = acc[2*W:W] + (acc[0] ? {1'b0, mcand} : '0);
        acc_step = {sum, acc[W-1:0]} >> 1;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (st) state_next = CALC;
            CALC:    if (cnt_zero) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        done = (state == DONE);
        idle = (state == IDLE);
    end

    // Datapath: operand capture, iteration and result write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            acc     <= '0;
            neg     <= 1'b0;
            produto <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (st) begin
                        mcand <= mag_a;
                        acc   <= {{(W+1){1'b0}}, mag_b};
                        neg   <= sinal & (multiplicando[W-1] ^ multiplicador[W-1]);
                    end
                end
                CALC: acc <= acc_step;
                FIX:  produto <= neg ? -acc[2*W-1:0] : acc[2*W-1:0];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multiplicador_sd_param.sv
module tb_multiplicador_sd_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        st4 = 1'b0, sinal4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  p4;
    logic        done4, idle4;

    logic        st8 = 1'b0, sinal8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] p8;
    logic        done8, idle8;

    int checks = 0;
    int errors = 0;
    int done4_cnt = 0;
    int done8_cnt = 0;

    logic [7:0]  q4[$];
    logic [15:0] q8[$];

    always #5 clk = ~clk;

    multiplicador_sd_param #(.W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .st(st4), .sinal(sinal4),
        .multiplicando(a4), .multiplicador(b4),
        .produto(p4), .done(done4), .idle(idle4)
    );

    multiplicador_sd_param #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .st(st8), .sinal(sinal8),
        .multiplicando(a8), .multiplicador(b8),
        .produto(p8), .done(done8), .idle(idle8)
    );

    function automatic logic [15:0] ref_mul(input int w, input logic s,
                                           input logic [7:0] a, input logic [7:0] b);
        int ia, ib, p, mask;
        mask = (1 << w) - 1;
        ia = int'(a) & mask;
        ib = int'(b) & mask;
        if (s && a[w-1]) ia = ia - (1 << w);
        if (s && b[w-1]) ib = ib - (1 << w);
        p = ia * ib;
        return 16'(p & ((1 << (2 * w)) - 1));
    endfunction

    // Scoreboard monitors: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (done4 === 1'b1) begin
            logic [7:0] e;
            done4_cnt++;
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL w4_unexpected_done produto=%h, no result expected", p4);
            end else begin
                e = q4.pop_front();
                if (p4 !== e) begin
                    errors++;
                    $display("FAIL w4_result got=%h expected=%h", p4, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            logic [15:0] e;
            done8_cnt++;
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL w8_unexpected_done produto=%h, no result expected", p8);
            end else begin
                e = q8.pop_front();
                if (p8 !== e) begin
                    errors++;
                    $display("FAIL w8_result got=%h expected=%h", p8, e);
                end
            end
        end
    end

    task automatic launch4_exp(input logic s, input logic [3:0] a, input logic [3:0] b,
                               input logic [7:0] e);
        st4 = 1'b1; sinal4 = s; a4 = a; b4 = b;
        q4.push_back(e);
    endtask

    task automatic launch4(input logic s, input logic [3:0] a, input logic [3:0] b);
        launch4_exp(s, a, b, 8'(ref_mul(4, s, {4'h0, a}, {4'h0, b})));
    endtask

    task automatic launch8_exp(input logic s, input logic [7:0] a, input logic [7:0] b,
                               input logic [15:0] e);
        st8 = 1'b1; sinal8 = s; a8 = a; b8 = b;
        q8.push_back(e);
    endtask

    task automatic launch8(input logic s, input logic [7:0] a, input logic [7:0] b);
        launch8_exp(s, a, b, ref_mul(8, s, a, b));
    endtask

    task automatic wait_idle4();
        int n = 0;
        while (!(q4.size() == 0 && idle4 === 1'b1) && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL w4_timeout pending=%0d idle=%b", q4.size(), idle4);
            q4.delete();
        end
    endtask

    task automatic wait_idle8();
        int n = 0;
        while (!(q8.size() == 0 && idle8 === 1'b1) && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL w8_timeout pending=%0d idle=%b", q8.size(), idle8);
            q8.delete();
        end
    endtask

    task automatic test_reset();
        #12;
        checks += 6;
        if (p4 !== 8'h00)     begin errors++; $display("FAIL reset_p4 got=%h expected=00", p4); end
        if (done4 !== 1'b0)   begin errors++; $display("FAIL reset_done4 got=%b expected=0", done4); end
        if (idle4 !== 1'b1)   begin errors++; $display("FAIL reset_idle4 got=%b expected=1", idle4); end
        if (p8 !== 16'h0000)  begin errors++; $display("FAIL reset_p8 got=%h expected=0000", p8); end
        if (done8 !== 1'b0)   begin errors++; $display("FAIL reset_done8 got=%b expected=0", done8); end
        if (idle8 !== 1'b1)   begin errors++; $display("FAIL reset_idle8 got=%b expected=1", idle8); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // 15x15 with exact edge-by-edge timing of produto, done and idle.
    task automatic test_unsigned_max();
        @(negedge clk);
        launch4_exp(1'b0, 4'd15, 4'd15, 8'hE1);
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k == 0) begin st4 = 1'b0; a4 = 4'd1; b4 = 4'd2; end
            checks += 3;
            if (done4 !== (k == 5)) begin
                errors++; $display("FAIL umax_done edge=%0d got=%b expected=%b", k, done4, (k == 5));
            end
            if (idle4 !== (k == 6)) begin
                errors++; $display("FAIL umax_idle edge=%0d got=%b expected=%b", k, idle4, (k == 6));
            end
            if (p4 !== ((k >= 5) ? 8'hE1 : 8'h00)) begin
                errors++; $display("FAIL umax_produto edge=%0d got=%h expected=%h",
                                   k, p4, ((k >= 5) ? 8'hE1 : 8'h00));
            end
        end
        wait_idle4();
    endtask

    task automatic test_signed();
        logic [3:0] av[3] = '{4'h8, 4'h8, 4'h5};
        logic [3:0] bv[3] = '{4'h8, 4'h7, 4'h0};
        logic [7:0] ev[3] = '{8'h40, 8'hC8, 8'h00};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            launch4_exp(1'b1, av[i], bv[i], ev[i]);
            @(negedge clk);
            st4 = 1'b0;
            wait_idle4();
        end
        @(negedge clk);
        launch4_exp(1'b1, 4'h7, 4'h3, 8'h15);
        @(negedge clk);
        st4 = 1'b0;
        wait_idle4();
    endtask

    // st held high; operands swapped while busy; each result must use its own start operands.
    task automatic test_back_to_back();
        int d0 = done4_cnt;
        @(negedge clk);
        launch4(1'b0, 4'd9, 4'd13);
        @(negedge clk);
        launch4(1'b1, 4'hB, 4'h6);
        repeat (7) @(negedge clk);
        launch4(1'b0, 4'd14, 4'd3);
        repeat (7) @(negedge clk);
        st4 = 1'b0; a4 = 4'hF; b4 = 4'hF; sinal4 = 1'b1;
        wait_idle4();
        checks++;
        if (done4_cnt - d0 !== 3) begin
            errors++; $display("FAIL b2b_done_count got=%0d expected=3", done4_cnt - d0);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        launch4(1'b0, 4'd7, 4'd7);
        @(negedge clk);
        st4 = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks += 3;
        if (p4 !== 8'h00)   begin errors++; $display("FAIL areset_p4 got=%h expected=00", p4); end
        if (idle4 !== 1'b1) begin errors++; $display("FAIL areset_idle4 got=%b expected=1", idle4); end
        if (done4 !== 1'b0) begin errors++; $display("FAIL areset_done4 got=%b expected=0", done4); end
        q4.delete();
        @(negedge clk);
        rst_n = 1'b1;
        launch4_exp(1'b0, 4'd3, 4'd5, 8'd15);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (k == 0) st4 = 1'b0;
            if (k >= 4) begin
                checks++;
                if (p4 !== ((k == 5) ? 8'd15 : 8'd0)) begin
                    errors++; $display("FAIL areset_3x5 edge=%0d got=%h expected=%h",
                                       k, p4, ((k == 5) ? 8'd15 : 8'd0));
                end
            end
        end
        wait_idle4();
    endtask

    task automatic test_w8();
        @(negedge clk);
        launch8_exp(1'b0, 8'd255, 8'd255, 16'd65025);
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            if (k == 0) st8 = 1'b0;
            if (k >= 8) begin
                checks += 2;
                if (p8 !== ((k == 9) ? 16'd65025 : 16'd0)) begin
                    errors++; $display("FAIL w8_umax_produto edge=%0d got=%h", k, p8);
                end
                if (done8 !== (k == 9)) begin
                    errors++; $display("FAIL w8_umax_done edge=%0d got=%b expected=%b", k, done8, (k == 9));
                end
            end
        end
        wait_idle8();
        @(negedge clk);
        launch8_exp(1'b1, 8'h80, 8'h7F, 16'hC080);
        @(negedge clk);
        st8 = 1'b0;
        wait_idle8();
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            launch4(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom));
            launch8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            @(negedge clk);
            st4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
            st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
            wait_idle4();
            wait_idle8();
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed();
        test_back_to_back();
        test_async_reset();
        test_w8();
        test_random();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
